// File: rtl/systolic_pkg.sv
// ============================================================================
// Module      : systolic_pkg
// Description : Shared state encoding and sizing helpers for the systolic tile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic int calc_nw(input int n, input int dw, input int bus_w);
        return (n * n * dw + bus_w - 1) / bus_w;
    endfunction

    function automatic int calc_nb(input int n, input int aw, input int bus_w);
        return (n * n * aw + bus_w - 1) / bus_w;
    endfunction

    function automatic int res_idx(input int k, input int j, input int n);
        return k * n + j;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_tile_ctrl_grid.sv
// ============================================================================
// Module      : systolic_grid
// Description : NxN weight-stationary PE mesh; activations flow right, partial
//               sums flow down, row i enters i cycles late.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_grid #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*N*DW-1:0] i_weights,
    input  logic [N*DW-1:0]   i_act,
    input  logic              i_valid,
    output logic [N*AW-1:0]   o_col_data,
    output logic [N-1:0]      o_col_valid
);

    logic [N*DW-1:0] w_row_act;
    logic [N-1:0]    w_row_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign w_row_act[DW-1:0] = i_act[DW-1:0];
            assign w_row_valid[0]    = i_valid;
        end else begin : g_delay
            logic [DW-1:0] r_sa [gi];
            logic [gi-1:0] r_sv;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < gi; s++) r_sa[s] <= '0;
                    r_sv <= '0;
                end else begin
                    r_sa[0] <= i_act[gi*DW +: DW];
                    r_sv[0] <= i_valid;
                    for (int s = 1; s < gi; s++) begin
                        r_sa[s] <= r_sa[s-1];
                        r_sv[s] <= r_sv[s-1];
                    end
                end
            end

            assign w_row_act[gi*DW +: DW] = r_sa[gi-1];
            assign w_row_valid[gi]        = r_sv[gi-1];
        end
    end

    logic [DW-1:0] r_a      [N][N];
    logic          r_v      [N][N];
    logic [AW-1:0] r_p      [N][N];
    logic [DW-1:0] w_a_left [N][N];
    logic          w_v_left [N][N];
    logic [AW-1:0] w_p_up   [N][N];

    // Operands are sign-extended to AW so the truncated product wraps mod 2^AW.
    function automatic logic [AW-1:0] f_mac(input logic [AW-1:0] acc,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] w);
        logic [AW-1:0] sa;
        logic [AW-1:0] sw;
        sa = {{(AW-DW){a[DW-1]}}, a};
        sw = {{(AW-DW){w[DW-1]}}, w};
        return acc + sa * sw;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) begin
                    w_a_left[i][j] = w_row_act[i*DW +: DW];
                    w_v_left[i][j] = w_row_valid[i];
                end else begin
                    w_a_left[i][j] = r_a[i][j-1];
                    w_v_left[i][j] = r_v[i][j-1];
                end
                if (i == 0) w_p_up[i][j] = '0;
                else        w_p_up[i][j] = r_p[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_v[i][j] <= 1'b0;
                    r_p[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= w_a_left[i][j];
                    r_v[i][j] <= w_v_left[i][j];
                    r_p[i][j] <= f_mac(w_p_up[i][j], w_a_left[i][j],
                                       i_weights[(i*N+j)*DW +: DW]);
                end
            end
        end
    end

    always_comb begin
        o_col_data  = '0;
        o_col_valid = '0;
        for (int j = 0; j < N; j++) begin
            o_col_data[j*AW +: AW] = r_p[N-1][j];
            o_col_valid[j]         = r_v[N-1][j];
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_tile_ctrl.sv
// ============================================================================
// Module      : systolic_tile_ctrl
// Description : Weight load, activation feed and result streaming controller
//               for an NxN systolic tile. Option macro: SYSTOLIC_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int BUS_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BUS_W-1:0]  cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N*DW-1:0]   act_data,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic              keep_weights,
    output logic [BUS_W-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_last,
    output logic              busy
);

    localparam int c_nw    = calc_nw(N, DW, BUS_W);
    localparam int c_nb    = calc_nb(N, AW, BUS_W);
    localparam int c_wbits = N * N * DW;
    localparam int c_rbits = N * N * AW;
    localparam int c_pbits = c_nb * BUS_W;
    localparam int c_wcw   = (c_nw > 1) ? $clog2(c_nw) : 1;
    localparam int c_bcw   = (c_nb > 1) ? $clog2(c_nb) : 1;
    localparam int c_acw   = $clog2(N + 1);

    localparam logic [c_acw-1:0] c_n     = c_acw'(N);
    localparam logic [c_wcw-1:0] c_wlast = c_wcw'(c_nw - 1);
    localparam logic [c_bcw-1:0] c_blast = c_bcw'(c_nb - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_wcw-1:0]   r_wcnt;
    logic [c_wbits-1:0] r_weights;
    logic [c_acw-1:0]   r_act_cnt;
    logic [c_acw-1:0]   r_col_cnt [N];
    logic [c_rbits-1:0] r_res_buf;
    logic [c_bcw-1:0]   r_beat;
    logic [c_pbits-1:0] w_res_pad;
    logic [N*AW-1:0]    w_col_data;
    logic [N-1:0]       w_col_valid;
    logic               w_all_done;
    logic               w_cfg_fire;
    logic               w_act_fire;
    logic               w_res_fire;
    logic               w_res_done;

    function automatic logic [AW-1:0] f_capture(input logic [AW-1:0] v);
`ifdef SYSTOLIC_RELU_EN
        return v[AW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    systolic_grid #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_grid (
        .clk         (clk),
        .reset       (reset),
        .i_weights   (r_weights),
        .i_act       (act_data),
        .i_valid     (w_act_fire),
        .o_col_data  (w_col_data),
        .o_col_valid (w_col_valid)
    );

    if (c_pbits > c_rbits) begin : g_pad
        assign w_res_pad = {{(c_pbits - c_rbits){1'b0}}, r_res_buf};
    end else begin : g_nopad
        assign w_res_pad = r_res_buf;
    end

    assign w_cfg_fire = cfg_valid & cfg_ready;
    assign w_act_fire = act_valid & act_ready;
    assign w_res_fire = res_valid & res_ready;
    assign w_res_done = w_res_fire & (r_beat == c_blast);

    always_comb begin
        w_all_done = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (r_col_cnt[j] != c_n) w_all_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_LOAD;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        cfg_ready    = 1'b0;
        act_ready    = 1'b0;
        res_valid    = 1'b0;
        res_last     = 1'b0;
        res_data     = '0;
        busy         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (w_cfg_fire && r_wcnt == c_wlast) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                busy      = 1'b1;
                act_ready = (r_act_cnt != c_n);
                if (w_all_done) w_next_state = ST_OUT;
            end
            ST_OUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_last  = (r_beat == c_blast);
                res_data  = w_res_pad[int'(r_beat)*BUS_W +: BUS_W];
                if (w_res_done) w_next_state = keep_weights ? ST_RUN : ST_LOAD;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt    <= '0;
            r_weights <= '0;
            r_act_cnt <= '0;
            r_res_buf <= '0;
            r_beat    <= '0;
            for (int j = 0; j < N; j++) r_col_cnt[j] <= '0;
        end else begin
            // Only bits below N*N*DW are kept; the tail of the last word is dropped.
            if (w_cfg_fire) begin
                for (int b = 0; b < c_wbits; b++) begin
                    if (b / BUS_W == int'(r_wcnt)) r_weights[b] <= cfg_data[b % BUS_W];
                end
                r_wcnt <= (r_wcnt == c_wlast) ? '0 : r_wcnt + 1'b1;
            end

            if (w_act_fire) r_act_cnt <= r_act_cnt + 1'b1;

            if (r_state == ST_RUN) begin
                for (int j = 0; j < N; j++) begin
                    if (w_col_valid[j] && r_col_cnt[j] != c_n) begin
                        r_res_buf[res_idx(int'(r_col_cnt[j]), j, N)*AW +: AW]
                            <= f_capture(w_col_data[j*AW +: AW]);
                        r_col_cnt[j] <= r_col_cnt[j] + 1'b1;
                    end
                end
            end

            if (w_res_fire) r_beat <= r_beat + 1'b1;

            if (w_res_done) begin
                r_beat    <= '0;
                r_act_cnt <= '0;
                r_res_buf <= '0;
                r_wcnt    <= '0;
                for (int j = 0; j < N; j++) r_col_cnt[j] <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
// ============================================================================
// Module      : tb_systolic_tile_ctrl
// Description : Directed table-driven bench for systolic_tile_ctrl (N=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_tile_ctrl;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int BUS_W = 32;
    localparam int NB    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [BUS_W-1:0] cfg_data;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N*DW-1:0]  act_data;
    logic             act_valid;
    logic             act_ready;
    logic             keep_weights;
    logic [BUS_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             res_last;
    logic             busy;

    always #5 clk = ~clk;

    systolic_tile_ctrl #(.N(N), .DW(DW), .AW(AW), .BUS_W(BUS_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .act_data     (act_data),
        .act_valid    (act_valid),
        .act_ready    (act_ready),
        .keep_weights (keep_weights),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_last     (res_last),
        .busy         (busy)
    );

    typedef struct packed {
        logic [2:0][31:0] cfg;   // [0] is the first word sent
        logic [2:0][23:0] act;   // [k] is vector k, element i in byte i
        logic [8:0][15:0] res;   // [k*3+j] raw wrapped result
    } vec_t;

    vec_t vecs [4];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef SYSTOLIC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] exp_beat(input logic [8:0][15:0] r, input int b);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = relu(r[2*b]);
        hi = 16'h0000;
        if (2*b + 1 < 9) hi = relu(r[2*b+1]);
        return {hi, lo};
    endfunction

    task automatic load_weights(input logic [2:0][31:0] cfg);
        for (int w = 0; w < 3; w++) begin
            int n;
            n = 0;
            cfg_data  = cfg[w];
            cfg_valid = 1'b1;
            while (!cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
            if (!cfg_ready) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        cfg_data  = '0;
    endtask

    task automatic send_acts(input logic [2:0][23:0] acts, input int gap);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            act_data  = acts[k];
            act_valid = 1'b1;
            while (!act_ready && n < 50) begin @(posedge clk); #1; n++; end
            if (!act_ready) check("act_ready_timeout", 32'(act_ready), 32'd1);
            @(posedge clk); #1;
            act_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic collect(input logic [8:0][15:0] r, input bit stall, input bit keep);
        int n;
        n = 0;
        while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!res_valid) check("res_valid_timeout", 32'(res_valid), 32'd1);
        for (int b = 0; b < NB; b++) begin
            if (stall) begin
                int s;
                s = 0;
                while ($urandom_range(0, 1) == 0 && s < 8) begin
                    res_ready = 1'b0;
                    check($sformatf("stall_beat%0d", b), res_data, exp_beat(r, b));
                    @(posedge clk); #1;
                    s++;
                end
            end
            res_ready    = 1'b1;
            keep_weights = keep;
            check($sformatf("valid%0d", b), 32'(res_valid), 32'd1);
            check($sformatf("beat%0d", b), res_data, exp_beat(r, b));
            check($sformatf("last%0d", b), 32'(res_last), (b == NB - 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        res_ready    = 1'b0;
        keep_weights = 1'b0;
        check("no_extra_beat", 32'(res_valid), 32'd0);
        check("cfg_ready_after", 32'(cfg_ready), keep ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [8:0][15:0] r_keep;

        vecs[0].cfg = {32'h00000001, 32'h00000001, 32'h00000001};
        vecs[0].act = {24'h090807, 24'h060504, 24'h030201};
        vecs[0].res = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

        vecs[1].cfg = {3{32'hFFFFFFFF}};
        vecs[1].act = {3{24'h030201}};
        vecs[1].res = {9{16'hFFFA}};

        vecs[2].cfg = {32'h00000009, 32'h08070605, 32'h04030201};
        vecs[2].act = {24'hFF0101, 24'h000100, 24'h000001};
        vecs[2].res = {16'h0000, 16'hFFFF, 16'hFFFE, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

        vecs[3].cfg = {3{32'h80808080}};
        vecs[3].act = {3{24'h808080}};
        vecs[3].res = {9{16'hC000}};

        r_keep = {16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd2};

        reset        = 1'b1;
        cfg_data     = '0;
        cfg_valid    = 1'b0;
        act_data     = '0;
        act_valid    = 1'b0;
        keep_weights = 1'b0;
        res_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_act_ready", 32'(act_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_last",  32'(res_last),  32'd0);
        check("rst_res_data",  res_data,       32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        for (int v = 0; v < 4; v++) begin
            load_weights(vecs[v].cfg);
            send_acts(vecs[v].act, 0);
            collect(vecs[v].res, 1'b0, 1'b0);
        end

        // Random backpressure on the result stream
        load_weights(vecs[0].cfg);
        send_acts(vecs[0].act, 0);
        collect(vecs[0].res, 1'b1, 1'b0);

        // Weight reuse: second batch runs on the retained identity weights
        load_weights(vecs[0].cfg);
        send_acts(vecs[0].act, 0);
        collect(vecs[0].res, 1'b0, 1'b1);
        check("keep_busy", 32'(busy), 32'd1);
        send_acts({3{24'h000002}}, 0);
        collect(r_keep, 1'b0, 1'b0);

        // Reset two cycles into RUN
        load_weights(vecs[2].cfg);
        act_data  = vecs[2].act[0];
        act_valid = 1'b1;
        @(posedge clk); #1;
        act_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_act_ready", 32'(act_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("postrst_res_valid", 32'(res_valid), 32'd0);
        load_weights(vecs[2].cfg);
        send_acts(vecs[2].act, 0);
        collect(vecs[2].res, 1'b0, 1'b0);

        // Sparse feeding, then an extra vector offered that must be refused
        load_weights(vecs[2].cfg);
        send_acts(vecs[2].act, 2);
        act_data  = 24'h7F7F7F;
        act_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("no_4th_accept", 32'(act_ready), 32'd0);
            @(posedge clk); #1;
        end
        act_valid = 1'b0;
        collect(vecs[2].res, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
